alu_issue_stage: RTL and testbench

//  Decode/issue stage that produces the ALU's 5-bit op select plus both operands from an RV32I instr.

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_issue_decode.sv | 100 ++++++++++
 rtl/alu_issue_stage.sv | 95 +++++++++
 tb/tb_alu_issue_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode/funct constants and the issue-entry record
// used by the ALU issue stage and its decoder.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] SUB  = 5'd1;
  localparam logic [4:0] AND  = 5'd2;
  localparam logic [4:0] OR   = 5'd3;
  localparam logic [4:0] SLTU = 5'd4;
  localparam logic [4:0] XOR  = 5'd5;
  localparam logic [4:0] SLL  = 5'd6;
  localparam logic [4:0] SRL  = 5'd7;
  localparam logic [4:0] SRA  = 5'd8;
  localparam logic [4:0] SLT  = 5'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [4:0]      signal;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_ZERO = '{
    signal:  5'd0,
    a:       32'd0,
    b:       32'd0,
    rd:      5'd0,
    wb_en:   1'b0,
    illegal: 1'b0
  };

  // funct3 -> op when funct7 selects the base (non-alternate) encoding
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ADD;
      3'b001:  op = SLL;
      3'b010:  op = SLT;
      3'b011:  op = SLTU;
      3'b100:  op = XOR;
      3'b101:  op = SRL;
      3'b110:  op = OR;
      3'b111:  op = AND;
      default: op = ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC: produces the ALU
// op select, both operands, rd and the write-back/illegal flags.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_entry_t    entry
);

  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] shamt_s;
  logic [4:0]      signal_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            legal_s;

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign f3_s     = instr[14:12];
  assign f7_s     = instr[31:25];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s  = {instr[31:12], 12'd0};
  assign shamt_s  = {27'd0, instr[24:20]};

  // Opcode/funct legality and operand selection
  always_comb begin
    signal_s = ADD;
    a_s      = 32'd0;
    b_s      = 32'd0;
    legal_s  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        a_s = rs1_data;
        b_s = rs2_data;
        if (f7_s == F7_BASE) begin
          legal_s  = 1'b1;
          signal_s = base_op(f3_s);
        end else if ((f7_s == F7_ALT) && (f3_s == F3_ADD)) begin
          legal_s  = 1'b1;
          signal_s = SUB;
        end else if ((f7_s == F7_ALT) && (f3_s == F3_SR)) begin
          legal_s  = 1'b1;
          signal_s = SRA;
        end else begin
          legal_s  = 1'b0;
        end
      end
      OPC_OPIMM: begin
        a_s      = rs1_data;
        b_s      = imm_i_s;
        signal_s = base_op(f3_s);
        // shift-immediates reuse the funct7 field, so only those are constrained
        if (f3_s == F3_SLL) begin
          b_s     = shamt_s;
          legal_s = (f7_s == F7_BASE);
        end else if (f3_s == F3_SR) begin
          b_s = shamt_s;
          if (f7_s == F7_BASE) begin
            legal_s = 1'b1;
          end else if (f7_s == F7_ALT) begin
            legal_s  = 1'b1;
            signal_s = SRA;
          end else begin
            legal_s = 1'b0;
          end
        end else begin
          legal_s = 1'b1;
        end
      end
      OPC_LUI: begin
        legal_s = 1'b1;
        b_s     = imm_u_s;
      end
      OPC_AUIPC: begin
        legal_s = 1'b1;
        a_s     = pc;
        b_s     = imm_u_s;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  assign entry.signal  = legal_s ? signal_s : ADD;
  assign entry.a       = legal_s ? a_s : 32'd0;
  assign entry.b       = legal_s ? b_s : 32'd0;
  assign entry.rd      = rd_s;
  assign entry.wb_en   = legal_s & (rd_s != 5'd0);
  assign entry.illegal = ~legal_s;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction and buffers the decoded ALU
// request in a 2-entry skid FIFO with a registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_signal,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);

  issue_entry_t mem_r [DEPTH];
  issue_entry_t dec_s;
  issue_entry_t head_s;
  logic         head_r;
  logic         tail_r;
  logic [1:0]   count_r;
  logic [1:0]   count_next_s;
  logic         in_ready_r;
  logic         push_s;
  logic         pop_s;

  alu_issue_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec_s)
  );

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = (count_r != 2'd0) & out_ready;

  // Occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and ready; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= 2'd0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      in_ready_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ENTRY_ZERO;
      end
    end else if (flush) begin
      count_r    <= 2'd0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= dec_s;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < 2'd2);
    end
  end

  assign head_s         = mem_r[head_r];
  assign in_ready       = in_ready_r;
  assign out_valid      = (count_r != 2'd0);
  assign out_alu_signal = head_s.signal;
  assign out_alu_a      = head_s.a;
  assign out_alu_b      = head_s.b;
  assign out_rd         = head_s.rd;
  assign out_wb_en      = head_s.wb_en;
  assign out_illegal    = head_s.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage, checked against a
// queue-based reference model of the decoder and the 2-entry buffer.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [4:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [4:0]  out_alu_signal, out_rd;
  logic [31:0] out_alu_a, out_alu_b;
  logic        out_wb_en, out_illegal;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic exp_rdy = 1'b0;
  logic zero_known = 1'b0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_signal(out_alu_signal), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [4:0] ops [8];
    logic signed [11:0] imm12;
    int simm, f3, f7, opc;
    bit ok;
    ops   = '{5'd0, 5'd6, 5'd9, 5'd4, 5'd5, 5'd7, 5'd3, 5'd2};
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    opc   = int'(ins[6:0]);
    imm12 = ins[31:20];
    simm  = imm12;
    ok    = 1'b0;
    e     = '0;
    e.rd  = ins[11:7];
    if (opc == 'h33) begin
      e.a = r1; e.b = r2;
      if (f7 == 0) begin ok = 1'b1; e.sig = ops[f3]; end
      else if (f7 == 32 && f3 == 0) begin ok = 1'b1; e.sig = 5'd1; end
      else if (f7 == 32 && f3 == 5) begin ok = 1'b1; e.sig = 5'd8; end
    end else if (opc == 'h13) begin
      e.a = r1;
      if (f3 == 1) begin
        ok = (f7 == 0); e.sig = 5'd6; e.b = 32'(ins[24:20]);
      end else if (f3 == 5) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 0) begin ok = 1'b1; e.sig = 5'd7; end
        else if (f7 == 32) begin ok = 1'b1; e.sig = 5'd8; end
      end else begin
        ok = 1'b1; e.sig = ops[f3]; e.b = 32'(simm);
      end
    end else if (opc == 'h37) begin
      ok = 1'b1; e.a = 32'd0; e.b = {ins[31:12], 12'd0};
    end else if (opc == 'h17) begin
      ok = 1'b1; e.a = pc; e.b = {ins[31:12], 12'd0};
    end
    if (!ok) begin e.sig = 5'd0; e.a = 32'd0; e.b = 32'd0; end
    e.ill = !ok;
    e.wb  = ok && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs
  task automatic cycle(input logic r, input logic f, input logic iv, input logic [31:0] ins,
      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
    exp_t h;
    bit pop, push;
    rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc;
    in_rs1_data = r1; in_rs2_data = r2; out_ready = ordy;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete(); exp_rdy = 1'b0; zero_known = 1'b1;
    end else if (f) begin
      q.delete(); exp_rdy = 1'b1;
    end else begin
      pop  = (q.size() > 0) && ordy;
      push = iv && exp_rdy;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(model_decode(ins, pc, r1, r2));
        zero_known = 1'b0;
      end
      exp_rdy = (q.size() < 2);
    end
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (q.size() > 0 || zero_known) begin
      h = (q.size() > 0) ? q[0] : '0;
      chk("signal", 32'(out_alu_signal), 32'(h.sig));
      chk("alu_a", out_alu_a, h.a);
      chk("alu_b", out_alu_b, h.b);
      chk("rd", 32'(out_rd), 32'(h.rd));
      chk("wb_en", 32'(out_wb_en), 32'(h.wb));
      chk("illegal", 32'(out_illegal), 32'(h.ill));
    end
  endtask

  function automatic logic [6:0] pick_f7();
    logic [31:0] v;
    v = $urandom;
    case (v[1:0])
      2'd0:    return 7'h00;
      2'd1:    return 7'h20;
      default: return v[8:2];
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 3) begin
      ins[6:0] = 7'h33; ins[31:25] = pick_f7();
    end else if (sel <= 6) begin
      ins[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 0) ins[31:25] = pick_f7();
    end else if (sel == 7) begin
      ins[6:0] = 7'h37;
    end else if (sel == 8) begin
      ins[6:0] = 7'h17;
    end
    return ins;
  endfunction

  logic [31:0] i_add, i_lui, i_aui;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;

    // reset and first ADD
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    i_add = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    cycle(1'b0, 1'b0, 1'b1, i_add, 32'd0, 32'd5, 32'd7, 1'b1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_sig", 32'(out_alu_signal), 32'd0);
    chk("add_a", out_alu_a, 32'd5);
    chk("add_b", out_alu_b, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_wb", 32'(out_wb_en), 32'd1);

    // immediates, each pushed while the previous head pops
    cycle(1'b0, 1'b0, 1'b1, i_type(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 32'd0, 32'd9, 32'd9, 1'b1);
    chk("addi_b", out_alu_b, 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, 1'b1, i_type(12'h404, 5'd1, 3'd5, 5'd1, 7'h13), 32'd0, 32'h80000000, 32'd0, 1'b1);
    chk("srai_sig", 32'(out_alu_signal), 32'd8);
    chk("srai_b", out_alu_b, 32'd4);
    cycle(1'b0, 1'b0, 1'b1, i_type(12'hFFF, 5'd1, 3'd3, 5'd2, 7'h13), 32'd0, 32'd1, 32'd0, 1'b1);
    chk("sltiu_sig", 32'(out_alu_signal), 32'd4);
    chk("sltiu_b", out_alu_b, 32'hFFFFFFFF);
    i_lui = u_type(20'h12345, 5'd5, 7'h37);
    cycle(1'b0, 1'b0, 1'b1, i_lui, 32'd0, 32'd3, 32'd3, 1'b1);
    chk("lui_a", out_alu_a, 32'd0);
    chk("lui_b", out_alu_b, 32'h12345000);
    i_aui = u_type(20'h00001, 5'd6, 7'h17);
    cycle(1'b0, 1'b0, 1'b1, i_aui, 32'h100, 32'd3, 32'd3, 1'b1);
    chk("auipc_a", out_alu_a, 32'h100);
    chk("auipc_b", out_alu_b, 32'h1000);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // back-pressure: third push waits for a pop
    cycle(1'b0, 1'b0, 1'b1, i_add, 32'd0, 32'd11, 32'd12, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, i_lui, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_a", out_alu_a, 32'd11);
    cycle(1'b0, 1'b0, 1'b1, i_aui, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("stall_head_a", out_alu_a, 32'd11);
    cycle(1'b0, 1'b0, 1'b1, i_aui, 32'h200, 32'd0, 32'd0, 1'b1);
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, i_aui, 32'h200, 32'd0, 32'd0, 1'b1);
    chk("third_a", out_alu_a, 32'h200);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // flush with a full buffer and a pending push
    cycle(1'b0, 1'b0, 1'b1, i_add, 32'd0, 32'd1, 32'd2, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, i_add, 32'd0, 32'd3, 32'd4, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, i_lui, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("flush_empty", 32'(out_valid), 32'd0);

    // illegal encodings and rd=x0
    cycle(1'b0, 1'b0, 1'b1, r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 32'd0, 32'd5, 32'd6, 1'b1);
    chk("bad_f7_ill", 32'(out_illegal), 32'd1);
    chk("bad_f7_wb", 32'(out_wb_en), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, i_type(12'h004, 5'd1, 3'd2, 5'd7, 7'h03), 32'd0, 32'd5, 32'd6, 1'b1);
    chk("load_ill", 32'(out_illegal), 32'd1);
    chk("load_b", out_alu_b, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'd0, 32'd5, 32'd6, 1'b1);
    chk("x0_ill", 32'(out_illegal), 32'd0);
    chk("x0_wb", 32'(out_wb_en), 32'd0);

    // reset mid-operation beats flush and push
    cycle(1'b0, 1'b0, 1'b1, i_lui, 32'd0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, i_aui, 32'h300, 32'd0, 32'd0, 1'b0);
    chk("midrst_b", out_alu_b, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
